stream_adder_nch: RTL and testbench

//  N-channel valid/ready stream adder, successor to the 2-input a+b adder in top.

---
 rtl/stream_adder_nch_if.sv | 23 ++
 rtl/stream_adder_nch.sv | 146 ++++++++++++++
 tb/tb_stream_adder_nch.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_adder_nch_if.sv
// Interface for the N-channel stream adder. It carries the per-channel input
// words, the valid/ready handshakes and the result port.
//   dinp      : channel words, ch i at [i*DATA_W +: DATA_W]
//   valid     : per-channel valid     ready     : per-channel ready
//   out       : narrowed sum          valid_out : out valid
//   ready_out : downstream ready      ovf       : result did not fit OUT_W
// The master modport is the source/sink side. The slave modport is the adder.
interface stream_adder_nch_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 16,
  parameter int OUT_W  = DATA_W + $clog2(N_CH)
);
  logic [N_CH*DATA_W-1:0] dinp;
  logic [N_CH-1:0]        valid;
  logic [N_CH-1:0]        ready;
  logic [OUT_W-1:0]       out;
  logic                   valid_out;
  logic                   ready_out;
  logic                   ovf;

  modport master (output dinp, valid, ready_out, input ready, out, valid_out, ovf);
  modport slave  (input dinp, valid, ready_out, output ready, out, valid_out, ovf);
endinterface

// File: rtl/stream_adder_nch.sv
// N-channel valid/ready stream adder. It joins one word from every input
// channel and sums the words in a registered pairwise adder tree with
// $clog2(N_CH) stages. A registered output stage follows the tree and narrows
// the result to OUT_W, either by saturating or by wrapping.
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, active low
//   st    : stream_adder_nch_if.slave (dinp/valid/ready in, out/valid_out/ovf out)
module stream_adder_nch #(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 16,
  parameter int SIGNED   = 0,
  parameter int OUT_W    = DATA_W + $clog2(N_CH),
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_adder_nch_if.slave st
);
  localparam int L      = $clog2(N_CH);
  localparam int FULL_W = DATA_W + L;

  // Number of operands that enter tree level k.
  function automatic int cnt_in(input int k);
    int c;
    c = N_CH;
    for (int j = 0; j < k; j++) c = (c + 1) / 2;
    return c;
  endfunction

  logic              up;
  logic [L-1:0]      v;
  logic [L-1:0]      adv;
  logic [L-1:0]      load;
  logic [L:0]        vv;
  logic [L:0]        aa;
  logic              adv_o;
  logic              accept;
  logic [FULL_W-1:0] sd     [L][N_CH];
  logic [FULL_W-1:0] sd_nxt [L][N_CH];
  logic [FULL_W-1:0] lvl    [L][2*N_CH];
  logic [FULL_W-1:0] sum;
  logic [OUT_W-1:0]  nar;
  logic              nar_ovf;

  // Handshake chain. A stage advances when it holds data and the stage after
  // it is empty or is itself advancing, so empty stages never stall the rest.
  always_comb begin
    adv_o = st.valid_out & st.ready_out;
    vv    = {st.valid_out, v};
    aa    = '0;
    aa[L] = adv_o;
    for (int k = L - 1; k >= 0; k--) aa[k] = vv[k] & (!vv[k+1] | aa[k+1]);
    adv    = aa[L-1:0];
    // The up flag keeps ready low until the first clock edge after reset.
    accept = up & (&st.valid) & (!v[0] | adv[0]);
    load   = '0;
    load[0] = accept;
    for (int k = 1; k < L; k++) load[k] = adv[k-1];
  end

  assign st.ready = {N_CH{accept}};

  // Operands are extended to FULL_W at the input. Because the final sum is
  // exact in FULL_W, adding at full width at every level gives the same
  // result as widening by one bit per level.
  always_comb begin
    for (int k = 0; k < L; k++)
      for (int i = 0; i < 2*N_CH; i++) lvl[k][i] = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (SIGNED != 0)
        lvl[0][i] = {{L{st.dinp[i*DATA_W+DATA_W-1]}}, st.dinp[i*DATA_W +: DATA_W]};
      else
        lvl[0][i] = {{L{1'b0}}, st.dinp[i*DATA_W +: DATA_W]};
    end
    for (int k = 1; k < L; k++)
      for (int i = 0; i < N_CH; i++) lvl[k][i] = sd[k-1][i];
    for (int k = 0; k < L; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (2*i + 1 < cnt_in(k))  sd_nxt[k][i] = lvl[k][2*i] + lvl[k][2*i+1];
        else if (2*i < cnt_in(k)) sd_nxt[k][i] = lvl[k][2*i];
        else                      sd_nxt[k][i] = '0;
      end
    end
  end

  assign sum = sd[L-1][0];

  generate
    if (OUT_W == FULL_W) begin : g_full
      assign nar     = sum;
      assign nar_ovf = 1'b0;
    end else if (SIGNED != 0) begin : g_signed
      // The result fits when the discarded bits and the new sign bit agree.
      logic [FULL_W-OUT_W:0] hi;
      logic                  fits;
      assign hi      = sum[FULL_W-1:OUT_W-1];
      assign fits    = (&hi) | ~(|hi);
      assign nar_ovf = ~fits;
      if (SATURATE != 0) begin : g_sat
        assign nar = fits ? sum[OUT_W-1:0] :
                     (sum[FULL_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
      end else begin : g_wrap
        assign nar = sum[OUT_W-1:0];
      end
    end else begin : g_unsigned
      logic fits;
      assign fits    = ~(|sum[FULL_W-1:OUT_W]);
      assign nar_ovf = ~fits;
      if (SATURATE != 0) begin : g_sat
        assign nar = fits ? sum[OUT_W-1:0] : {OUT_W{1'b1}};
      end else begin : g_wrap
        assign nar = sum[OUT_W-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up           <= 1'b0;
      v            <= '0;
      for (int k = 0; k < L; k++)
        for (int i = 0; i < N_CH; i++) sd[k][i] <= '0;
      st.valid_out <= 1'b0;
      st.out       <= '0;
      st.ovf       <= 1'b0;
    end else begin
      up <= 1'b1;
      for (int k = 0; k < L; k++) begin
        if (load[k]) begin
          v[k] <= 1'b1;
          for (int i = 0; i < N_CH; i++) sd[k][i] <= sd_nxt[k][i];
        end else if (adv[k]) begin
          v[k] <= 1'b0;
        end
      end
      if (adv[L-1]) begin
        st.valid_out <= 1'b1;
        st.out       <= nar;
        st.ovf       <= nar_ovf;
      end else if (adv_o) begin
        st.valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_adder_nch.sv
// Scoreboard bench for stream_adder_nch. Five configurations run side by side.
// The stimulus tasks push {ovf, out} expectations when an accept is seen.
// Per-instance monitors pop and compare whenever valid_out & ready_out.
module tb_stream_adder_nch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  stream_adder_nch_if #(.N_CH(2), .DATA_W(16), .OUT_W(17)) a_if();
  stream_adder_nch_if #(.N_CH(4), .DATA_W(8),  .OUT_W(10)) b_if();
  stream_adder_nch_if #(.N_CH(4), .DATA_W(8),  .OUT_W(8))  c_if();
  stream_adder_nch_if #(.N_CH(4), .DATA_W(8),  .OUT_W(8))  d_if();
  stream_adder_nch_if #(.N_CH(3), .DATA_W(8),  .OUT_W(8))  e_if();

  stream_adder_nch #(.N_CH(2), .DATA_W(16), .SIGNED(0), .OUT_W(17), .SATURATE(1))
    u_a (.clk(clk), .rst_n(rst_n), .st(a_if.slave));
  stream_adder_nch #(.N_CH(4), .DATA_W(8), .SIGNED(0), .OUT_W(10), .SATURATE(1))
    u_b (.clk(clk), .rst_n(rst_n), .st(b_if.slave));
  stream_adder_nch #(.N_CH(4), .DATA_W(8), .SIGNED(0), .OUT_W(8), .SATURATE(1))
    u_c (.clk(clk), .rst_n(rst_n), .st(c_if.slave));
  stream_adder_nch #(.N_CH(4), .DATA_W(8), .SIGNED(0), .OUT_W(8), .SATURATE(0))
    u_d (.clk(clk), .rst_n(rst_n), .st(d_if.slave));
  stream_adder_nch #(.N_CH(3), .DATA_W(8), .SIGNED(1), .OUT_W(8), .SATURATE(1))
    u_e (.clk(clk), .rst_n(rst_n), .st(e_if.slave));

  // The c and d instances see exactly the same stimulus as b.
  assign c_if.dinp = b_if.dinp;
  assign c_if.valid = b_if.valid;
  assign c_if.ready_out = b_if.ready_out;
  assign d_if.dinp = b_if.dinp;
  assign d_if.valid = b_if.valid;
  assign d_if.ready_out = b_if.ready_out;

  logic [31:0] a_q[$], b_q[$], c_q[$], d_q[$], e_q[$];
  int a_idx = 0, a_acc = 0, a_stall = 0, a_outs = 0;
  int a_first_acc = -1, a_first_out = -1;
  int b_acc_cyc = 0, b_last_cyc = 0;
  int e_outs = 0;
  logic a_held = 1'b0;
  logic [31:0] a_hold_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_output required=no_output", nm);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (a_if.valid_out && a_if.ready_out) begin
      a_outs++;
      if (a_first_out < 0) a_first_out = cyc;
      if (a_q.size() == 0) extra("a_sum");
      else chk("a_sum", 32'({a_if.ovf, a_if.out}), a_q.pop_front());
    end
    if (a_held) chk("a_hold", 32'({a_if.valid_out, a_if.ovf, a_if.out}), a_hold_val);
    a_held = rst_n && a_if.valid_out && !a_if.ready_out;
    a_hold_val = 32'({1'b1, a_if.ovf, a_if.out});
  end

  always @(negedge clk) begin
    if (b_if.valid_out && b_if.ready_out) begin
      b_last_cyc = cyc;
      if (b_q.size() == 0) extra("b_sum");
      else chk("b_sum", 32'({b_if.ovf, b_if.out}), b_q.pop_front());
    end
    if (c_if.valid_out && c_if.ready_out) begin
      if (c_q.size() == 0) extra("c_sat");
      else chk("c_sat", 32'({c_if.ovf, c_if.out}), c_q.pop_front());
    end
    if (d_if.valid_out && d_if.ready_out) begin
      if (d_q.size() == 0) extra("d_wrap");
      else chk("d_wrap", 32'({d_if.ovf, d_if.out}), d_q.pop_front());
    end
    if (e_if.valid_out && e_if.ready_out) begin
      e_outs++;
      if (e_q.size() == 0) extra("e_signed");
      else chk("e_signed", 32'({e_if.ovf, e_if.out}), e_q.pop_front());
    end
  end

  // Stimulus tasks
  task automatic a_run(input int n);
    for (int k = 0; k < n; k++) begin
      logic took;
      took = 1'b0;
      @(negedge clk);
      if (a_if.valid == 2'b11) begin
        if (a_if.ready == 2'b11) begin
          a_q.push_back(32'(3 + 2 * a_idx));
          a_acc++;
          if (a_first_acc < 0) a_first_acc = cyc;
          took = 1'b1;
        end else begin
          a_stall++;
        end
      end
      @(posedge clk); #1;
      if (took) begin
        a_idx++;
        a_if.dinp = {16'(2 + a_idx), 16'(1 + a_idx)};
      end
    end
  endtask

  task automatic b_send(input logic [7:0] x0, x1, x2, x3,
                        input logic [31:0] eb, ec, ed);
    logic ok;
    ok = 1'b0;
    b_if.dinp = {x3, x2, x1, x0};
    b_if.valid = 4'hF;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (b_if.ready == 4'hF) begin
        b_q.push_back(eb); c_q.push_back(ec); d_q.push_back(ed);
        b_acc_cyc = cyc;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("b_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic e_send(input int x0, x1, x2, input logic [31:0] ee);
    logic ok;
    ok = 1'b0;
    e_if.dinp = {8'(x2), 8'(x1), 8'(x0)};
    e_if.valid = 3'b111;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (e_if.ready == 3'b111) begin
        e_q.push_back(ee);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("e_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0, st0, outs0;
    rst_n = 1'b0;
    a_if.dinp = {16'd2, 16'd1}; a_if.valid = 2'b11; a_if.ready_out = 1'b1;
    b_if.dinp = '0; b_if.valid = 4'hF; b_if.ready_out = 1'b1;
    e_if.dinp = '0; e_if.valid = 3'b111; e_if.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", 32'(a_if.ready), 32'd0);
    chk("rst_a_valid_out", 32'(a_if.valid_out), 32'd0);
    chk("rst_a_out", 32'(a_if.out), 32'd0);
    chk("rst_a_ovf", 32'(a_if.ovf), 32'd0);
    chk("rst_b_ready", 32'(b_if.ready), 32'd0);
    chk("rst_e_ready", 32'(e_if.ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_if.valid = 2'b00; b_if.valid = 4'h0; e_if.valid = 3'b000;
    repeat (2) @(posedge clk); #1;

    // Streaming sums at full throughput
    a_if.valid = 2'b11;
    a_run(20);
    chk("t1_accepts", 32'(a_acc), 32'd20);
    chk("t1_ready_every_cycle", 32'(a_stall), 32'd0);
    a_if.valid = 2'b00;
    repeat (5) @(posedge clk); #1;
    chk("t1_latency", 32'(a_first_out - a_first_acc), 32'd2);
    chk("t1_drained", 32'(a_q.size()), 32'd0);

    // Backpressure
    a_if.ready_out = 1'b0;
    acc0 = a_acc; st0 = a_stall;
    a_if.valid = 2'b11;
    a_run(10);
    chk("bp_accepts", 32'(a_acc - acc0), 32'd2);
    chk("bp_stalled_cycles", 32'(a_stall - st0), 32'd8);
    @(negedge clk);
    chk("bp_ready_low", 32'(a_if.ready), 32'd0);
    chk("bp_valid_out_held", 32'(a_if.valid_out), 32'd1);
    @(posedge clk); #1;
    a_if.ready_out = 1'b1;
    a_run(6);
    a_if.valid = 2'b00;
    repeat (6) @(posedge clk); #1;
    chk("bp_no_loss_dup", 32'(a_outs), 32'(a_acc));
    chk("bp_drained", 32'(a_q.size()), 32'd0);

    // Four-channel full width, saturation and wrap
    b_send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'h3FC, 32'h1FF, 32'h1FC);
    acc0 = b_acc_cyc;
    b_if.valid = 4'h0;
    repeat (6) @(posedge clk); #1;
    chk("t2_latency", 32'(b_last_cyc - acc0), 32'd3);
    b_send(8'd200, 8'd100, 8'd1, 8'd1, 32'h12E, 32'h1FF, 32'h12E);
    b_send(8'd10, 8'd20, 8'd30, 8'd40, 32'h064, 32'h064, 32'h064);
    b_send(8'd255, 8'd0, 8'd0, 8'd0, 32'h0FF, 32'h0FF, 32'h0FF);
    b_send(8'd128, 8'd128, 8'd0, 8'd0, 32'h100, 32'h1FF, 32'h100);
    b_if.valid = 4'h0;
    repeat (6) @(posedge clk); #1;
    chk("bcd_drained", 32'(b_q.size() + c_q.size() + d_q.size()), 32'd0);

    // Signed three-channel with clamping
    e_send(-128, -128, -1, 32'h180);
    e_send(5, -3, -2, 32'h000);
    e_send(100, 100, 100, 32'h17F);
    e_send(-1, -1, -1, 32'h0FD);
    e_send(-100, -100, -100, 32'h180);
    e_if.dinp = {8'd3, 8'd2, 8'd1};
    e_if.valid = 3'b011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_ready_ch2_low", 32'(e_if.ready), 32'd0);
      @(posedge clk); #1;
    end
    e_send(1, 2, 3, 32'h006);
    e_if.valid = 3'b000;
    repeat (6) @(posedge clk); #1;
    chk("e_drained", 32'(e_q.size()), 32'd0);

    // Reset with sums in flight and the output stalled
    e_if.ready_out = 1'b0;
    e_send(10, 10, 10, 32'h01E);
    e_send(20, 20, 20, 32'h03C);
    e_send(30, 30, 30, 32'h05A);
    chk("rst_pre_valid_out", 32'(e_if.valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid_out", 32'(e_if.valid_out), 32'd0);
    chk("rst_mid_ready", 32'(e_if.ready), 32'd0);
    e_q.delete();
    outs0 = e_outs;
    e_if.valid = 3'b000;
    e_if.ready_out = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("rst_no_output_after", 32'(e_outs - outs0), 32'd0);
    e_send(7, -7, 1, 32'h001);
    e_if.valid = 3'b000;
    repeat (6) @(posedge clk); #1;
    chk("rst_recovered", 32'(e_outs - outs0), 32'd1);
    chk("all_drained", 32'(a_q.size() + b_q.size() + c_q.size() + d_q.size() + e_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
